// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one single-port block RAM between VGA scan fetch,
// CPU load/store and the PS/2 scancode writer.
//   - VGA has fixed top priority.
//   - CPU and PS/2 alternate round-robin using a last-served pointer.
//   - Read data returns one cycle after the grant and is tagged by *_rvalid.
// Optional build macro: ARB_STARVE_GUARD_EN. When it is defined, a held CPU
// request is granted over VGA after STARVE_LIMIT consecutive VGA grants.
//
// Handshake: *_req acts as "valid" and *_gnt as "ready". An access transfers
// on the rising edge that ends a cycle with req & gnt. While req & !gnt, the
// requester keeps addr/wdata/we stable. It may present its next access on the
// same edge as a grant, so accesses can run back-to-back at one per cycle.
module vram_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              inCLK_50MHZ,
  input  logic              BTN_NORTH,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              kbd_req,
  input  logic [ADDR_W-1:0] kbd_addr,
  input  logic [DATA_W-1:0] kbd_wdata,
  output logic              kbd_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata
);

  // rr_last: 0 = CPU was served last, 1 = PS/2 was served last.
  logic rr_last;
  logic tag_vga;
  logic tag_cpu;
  logic starve_force;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_cnt;

  // Once VGA has taken LIMIT grants in a row while the CPU waited, the CPU
  // gets the next access.
  assign starve_force = cpu_req && (starve_cnt == LIMIT);

  // Count consecutive VGA grants while the CPU is waiting. The count clears
  // when the CPU drops its request or is served.
  always_ff @(posedge inCLK_50MHZ) begin
    if (BTN_NORTH) begin
      starve_cnt <= '0;
    end else if (!cpu_req || cpu_gnt) begin
      starve_cnt <= '0;
    end else if (vga_gnt && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // Strict VGA priority: the CPU may wait indefinitely behind VGA.
  assign starve_force = 1'b0;
`endif

  // Select at most one winner per cycle. No grant is issued while reset is held.
  always_comb begin
    vga_gnt = 1'b0;
    cpu_gnt = 1'b0;
    kbd_gnt = 1'b0;
    if (!BTN_NORTH) begin
      if (starve_force) begin
        cpu_gnt = 1'b1;
      end else if (vga_req) begin
        vga_gnt = 1'b1;
      end else if (cpu_req && (!kbd_req || rr_last)) begin
        cpu_gnt = 1'b1;
      end else if (kbd_req) begin
        kbd_gnt = 1'b1;
      end
    end
  end

  // Drive the RAM port from the winner. When idle, address and data are zero.
  always_comb begin
    mem_en    = vga_gnt | cpu_gnt | kbd_gnt;
    mem_we    = (cpu_gnt & cpu_we) | kbd_gnt;
    mem_addr  = '0;
    mem_wdata = '0;
    if (vga_gnt) begin
      mem_addr = vga_addr;
    end else if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (kbd_gnt) begin
      mem_addr  = kbd_addr;
      mem_wdata = kbd_wdata;
    end
  end

  // Move the round-robin pointer only when the CPU or PS/2 is served.
  always_ff @(posedge inCLK_50MHZ) begin
    if (BTN_NORTH) begin
      rr_last <= 1'b1;
    end else if (cpu_gnt) begin
      rr_last <= 1'b0;
    end else if (kbd_gnt) begin
      rr_last <= 1'b1;
    end
  end

  // Record which requester owns the read data that arrives on the next cycle.
  always_ff @(posedge inCLK_50MHZ) begin
    if (BTN_NORTH) begin
      tag_vga <= 1'b0;
      tag_cpu <= 1'b0;
    end else begin
      tag_vga <= vga_gnt;
      tag_cpu <= cpu_gnt & ~cpu_we;
    end
  end

  // Suppress rvalid while reset is held. This drops a read that was granted
  // just before reset.
  assign vga_rvalid = tag_vga & ~BTN_NORTH;
  assign cpu_rvalid = tag_cpu & ~BTN_NORTH;
  assign rdata      = mem_rdata;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed, table-driven bench for vram_port_arbiter, with a behavioural RAM.
// The starvation sequence follows the ARB_STARVE_GUARD_EN build setting.
module tb_vram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req, cpu_req, cpu_we, kbd_req;
  logic [15:0] vga_addr, cpu_addr, cpu_wdata, kbd_addr, kbd_wdata;
  logic        vga_gnt, vga_rvalid, cpu_gnt, cpu_rvalid, kbd_gnt;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, rdata;
  logic [15:0] ram [0:65535];

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst;
    logic        vr;
    logic [15:0] va;
    logic        cr;
    logic        cw;
    logic [15:0] ca;
    logic [15:0] cd;
    logic        kr;
    logic [15:0] ka;
    logic [15:0] kd;
    logic [2:0]  e_gnt;   // {vga, cpu, kbd}
    logic [1:0]  e_rv;    // {vga, cpu}
    logic        e_en;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  // clock / reset
  always #5 clk = ~clk;

  vram_port_arbiter dut (
    .inCLK_50MHZ (clk),
    .BTN_NORTH   (rst),
    .vga_req     (vga_req),
    .vga_addr    (vga_addr),
    .vga_gnt     (vga_gnt),
    .vga_rvalid  (vga_rvalid),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_rvalid  (cpu_rvalid),
    .kbd_req     (kbd_req),
    .kbd_addr    (kbd_addr),
    .kbd_wdata   (kbd_wdata),
    .kbd_gnt     (kbd_gnt),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .rdata       (rdata)
  );

  // behavioural single-port RAM, read latency 1
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  function automatic vec_t mk(
    input logic rs, input logic vr, input logic [15:0] va,
    input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
    input logic kr, input logic [15:0] ka, input logic [15:0] kd,
    input logic [2:0] eg, input logic [1:0] ev, input logic een, input logic ewe,
    input logic [15:0] ead, input logic [15:0] ewd, input logic [15:0] erd);
    vec_t v;
    v.rst = rs; v.vr = vr; v.va = va; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.kr = kr; v.ka = ka; v.kd = kd; v.e_gnt = eg; v.e_rv = ev; v.e_en = een;
    v.e_we = ewe; v.e_addr = ead; v.e_wdata = ewd; v.e_rdata = erd;
    return v;
  endfunction

  // driver
  task automatic drive(input logic rs, input logic vr, input logic [15:0] va,
                       input logic cr, input logic cw, input logic [15:0] ca,
                       input logic [15:0] cd, input logic kr, input logic [15:0] ka,
                       input logic [15:0] kd);
    rst = rs; vga_req = vr; vga_addr = va; cpu_req = cr; cpu_we = cw;
    cpu_addr = ca; cpu_wdata = cd; kbd_req = kr; kbd_addr = ka; kbd_wdata = kd;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 16'h0000;
    ram[16'h0010] = 16'hBEEF;
    for (int k = 0; k < 4; k++) ram[16'h0100 + k] = 16'hA000 + 16'(k);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);

    //          rst vr va       cr cw ca       cd       kr ka       kd       gnt     rv     en we addr     wdata    rdata
    // reset, with and without requests
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b000, 2'b00, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 1, 16'h0100, 1, 0, 16'h0010, 16'h0000, 1, 16'h3000, 16'h0055, 3'b000, 2'b00, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    // all three request: VGA wins 3 cycles
    vecs.push_back(mk(0, 1, 16'h0100, 1, 0, 16'h0010, 16'h0000, 1, 16'h3000, 16'h0055, 3'b100, 2'b00, 1, 0, 16'h0100, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 1, 16'h0100, 1, 0, 16'h0010, 16'h0000, 1, 16'h3000, 16'h0055, 3'b100, 2'b10, 1, 0, 16'h0100, 16'h0000, 16'hA000));
    vecs.push_back(mk(0, 1, 16'h0100, 1, 0, 16'h0010, 16'h0000, 1, 16'h3000, 16'h0055, 3'b100, 2'b10, 1, 0, 16'h0100, 16'h0000, 16'hA000));
    // VGA drops: CPU first after reset, then PS/2, alternating
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 1, 16'h3000, 16'h0055, 3'b010, 2'b10, 1, 0, 16'h0010, 16'h0000, 16'hA000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 1, 16'h3000, 16'h0055, 3'b001, 2'b01, 1, 1, 16'h3000, 16'h0055, 16'hBEEF));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 1, 16'h3000, 16'h0055, 3'b010, 2'b00, 1, 0, 16'h0010, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 1, 16'h3000, 16'h0055, 3'b001, 2'b01, 1, 1, 16'h3000, 16'h0055, 16'hBEEF));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b000, 2'b00, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    // lone CPU read of 0x0010
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 16'h0000, 3'b010, 2'b00, 1, 0, 16'h0010, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b000, 2'b01, 0, 0, 16'h0000, 16'h0000, 16'hBEEF));
    // VGA back-to-back 0x0100..0x0103
    vecs.push_back(mk(0, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b100, 2'b00, 1, 0, 16'h0100, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 1, 16'h0101, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b100, 2'b10, 1, 0, 16'h0101, 16'h0000, 16'hA000));
    vecs.push_back(mk(0, 1, 16'h0102, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b100, 2'b10, 1, 0, 16'h0102, 16'h0000, 16'hA001));
    vecs.push_back(mk(0, 1, 16'h0103, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b100, 2'b10, 1, 0, 16'h0103, 16'h0000, 16'hA002));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b000, 2'b10, 0, 0, 16'h0000, 16'h0000, 16'hA003));
    // PS/2 writes 0x001C to 0x2000, CPU reads it back
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h2000, 16'h001C, 3'b001, 2'b00, 1, 1, 16'h2000, 16'h001C, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h2000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b010, 2'b00, 1, 0, 16'h2000, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b000, 2'b01, 0, 0, 16'h0000, 16'h0000, 16'h001C));
    // CPU write produces no rvalid
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h2001, 16'h1234, 0, 16'h0000, 16'h0000, 3'b010, 2'b00, 1, 1, 16'h2001, 16'h1234, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b000, 2'b00, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    // reset right after a CPU read grant discards the read; CPU first afterwards
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 16'h0000, 3'b010, 2'b00, 1, 0, 16'h0010, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b000, 2'b00, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b000, 2'b00, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 1, 16'h3000, 16'h0077, 3'b010, 2'b00, 1, 0, 16'h0010, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 3'b000, 2'b01, 0, 0, 16'h0000, 16'h0000, 16'hBEEF));

    // apply the table: drive 1 time unit after the edge, check on the falling edge
    @(posedge clk);
    foreach (vecs[i]) begin
      #1;
      drive(vecs[i].rst, vecs[i].vr, vecs[i].va, vecs[i].cr, vecs[i].cw, vecs[i].ca,
            vecs[i].cd, vecs[i].kr, vecs[i].ka, vecs[i].kd);
      @(negedge clk);
      chk("gnt",      i, {13'd0, vga_gnt, cpu_gnt, kbd_gnt}, {13'd0, vecs[i].e_gnt});
      chk("rvalid",   i, {14'd0, vga_rvalid, cpu_rvalid},    {14'd0, vecs[i].e_rv});
      chk("mem_en",   i, {15'd0, mem_en},                    {15'd0, vecs[i].e_en});
      chk("mem_we",   i, {15'd0, mem_we},                    {15'd0, vecs[i].e_we});
      chk("mem_addr", i, mem_addr,                           vecs[i].e_addr);
      chk("mem_wdata", i, mem_wdata,                         vecs[i].e_wdata);
      if (vecs[i].e_rv != 2'b00) chk("rdata", i, rdata, vecs[i].e_rdata);
      @(posedge clk);
    end

    // starvation sequence: VGA and CPU both held after a reset
    #1;
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    for (int k = 0; k < 27; k++) begin
      logic e_cpu;
`ifdef ARB_STARVE_GUARD_EN
      e_cpu = ((k % 9) == 8);
`else
      e_cpu = 1'b0;
`endif
      #1;
      drive(1'b0, 1'b1, 16'h0200, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      chk("starve_vga_gnt", k, {15'd0, vga_gnt}, {15'd0, ~e_cpu});
      chk("starve_cpu_gnt", k, {15'd0, cpu_gnt}, {15'd0, e_cpu});
      @(posedge clk);
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
